mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Reset is asynchronous and active-high; the block uses one clock.
REQ-002 Parameter LATENCY, default 2, cycles from mem_en to valid mem_rdata; legal range 1..15.
REQ-003 Parameter STREAK_MAX, default 4, consecutive data grants allowed while fetch waits; legal range 1..15.
REQ-004 clk  in  1  rising-edge system clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 i_req in 1 fetch request; i_addr in 32 fetch address; i_ready out 1 fetch accept pulse.
REQ-007 i_valid out 1 fetch response pulse; i_rdata out 32 fetch instruction word.
REQ-008 d_req in 1 data request; d_we in 1 write flag; d_addr in 32; d_wdata in 32; d_wstrb in 4 byte enables.
REQ-009 d_ready out 1 data accept pulse; d_valid out 1 data response pulse; d_rdata out 32 load data.
REQ-010 mem_en out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_wstrb out 4: single-port memory command.
REQ-011 mem_rdata in 32 read data, valid exactly LATENCY cycles after the mem_en cycle.

Function
REQ-012 FSM states IDLE, BUSY, RESP; exactly one transaction outstanding at any time.
REQ-013 IDLE, any req high: grant in the same cycle; winner's x_ready=1, mem_en=1, mem_addr/we/wdata/wstrb driven combinationally from the winner; next state BUSY.
REQ-014 Fetch grants drive mem_we=0 and mem_wstrb=0; with no grant, mem_en=0 and all other mem_* outputs are 0.
REQ-015 Arbitration: data wins when both request, except as modified under Configuration.
REQ-016 BUSY: a 4-bit counter loaded with LATENCY-1 at grant and decremented each cycle; at 0, mem_rdata is registered and next state RESP.
REQ-017 RESP: the granted port's x_valid=1 for exactly one cycle with registered data; the FSM evaluates requests that cycle exactly as in IDLE (back-to-back grant allowed).
REQ-018 Accept-to-response latency = LATENCY+1 cycles; peak throughput one transaction per LATENCY+1 cycles.
REQ-019 Data write: mem_we=1 at grant; d_valid is still pulsed at LATENCY+1 as acknowledge, with d_rdata=0.
REQ-020 i_rdata/d_rdata hold their last value between valid pulses; the non-granted port's valid stays 0.
REQ-021 Requesters hold req and payload stable until ready; deasserting req before ready withdraws it without side effect.
REQ-022 req seen during BUSY is not accepted; ready stays 0 until IDLE/RESP.
REQ-023 d_wstrb=0 on a write still issues mem_en and acknowledges normally.

Reset
REQ-024 rst high: state IDLE, counter 0, streak 0, all ready/valid 0, i_rdata/d_rdata 0, mem_en/mem_we 0.
REQ-025 rst mid-transaction aborts it: no valid pulse issued, late mem_rdata ignored, first grant possible in the first cycle after rst falls.

Configuration
REQ-026 Macro ARB_STARVE_GUARD_EN compiled in: a streak counter counts consecutive data grants made while i_req was high; when it equals STARVE_GUARD, the next grant with i_req high goes to fetch.
REQ-027 Streak counter clears on any fetch grant and on any data grant with i_req low; STARVE_GUARD = STREAK_MAX.
REQ-028 Macro ARB_STARVE_GUARD_EN absent: strict data priority, no streak counter, STREAK_MAX unused.

Verification
REQ-029 LATENCY=2, i_req alone, i_addr=0x10, mem_rdata=0x00208033 two cycles after grant: i_ready at cycle 0, i_valid with i_rdata=0x00208033 at cycle 3.
REQ-030 i_req and d_req (read 0x40) high together: d_ready first; i_ready in the d_valid cycle (cycle 3); i_valid at cycle 6.
REQ-031 Write d_addr=0x80, d_wdata=0xDEADBEEF, d_wstrb=0xF: mem_we=1 with matching payload at grant; d_valid=1, d_rdata=0 at cycle 3.
REQ-032 d_req and i_req held high continuously, guard enabled, STREAK_MAX=4: grant order D,D,D,D,I,D,D,D,D,I; guard disabled: only D grants.
REQ-033 rst pulsed during BUSY of a read: no i_valid/d_valid ever for that read; new request after rst falls granted next cycle with normal latency.

Source files
------------

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port, fixed-latency memory; one transaction in flight.
// Define ARB_STARVE_GUARD_EN to stop a continuous data stream from starving fetch indefinitely.
module mem_arbiter #(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned STREAK_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic        i_valid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ready,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : gLatencyCheck
        $error("mem_arbiter: LATENCY must be within 1..15");
    end
    if (STREAK_MAX < 1 || STREAK_MAX > 15) begin : gStreakCheck
        $error("mem_arbiter: STREAK_MAX must be within 1..15");
    end

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ownerData_q, ownerData_d;
    logic        ownerWrite_q, ownerWrite_d;
    logic [31:0] iRdata_q, iRdata_d;
    logic [31:0] dRdata_q, dRdata_d;
    logic        grant;
    logic        pickData;
    logic        fetchForced;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_GUARD = 4'(STREAK_MAX);
    logic [3:0] streak_q, streak_d;

    // Counts back-to-back data grants that left a waiting fetch behind.
    assign fetchForced = i_req && (streak_q == STARVE_GUARD);

    always_comb begin
        streak_d = streak_q;
        if (grant) begin
            streak_d = (pickData && i_req) ? streak_q + 4'd1 : 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    assign fetchForced = 1'b0;
`endif

    assign pickData = d_req && !fetchForced;

    assign i_valid = (state_q == RESP) && !ownerData_q;
    assign d_valid = (state_q == RESP) && ownerData_q;
    assign i_rdata = iRdata_q;
    assign d_rdata = dRdata_q;

    // RESP shares the grant path with IDLE so a new request can start while the response is shown.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ownerData_d  = ownerData_q;
        ownerWrite_d = ownerWrite_q;
        iRdata_d     = iRdata_q;
        dRdata_d     = dRdata_q;
        grant        = 1'b0;
        i_ready      = 1'b0;
        d_ready      = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_wstrb    = '0;
        case (state_q)
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    if (ownerData_q) begin
                        dRdata_d = ownerWrite_q ? 32'd0 : mem_rdata;
                    end else begin
                        iRdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                if (!rst && (i_req || d_req)) begin
                    grant        = 1'b1;
                    state_d      = BUSY;
                    cnt_d        = CNT_LOAD;
                    ownerData_d  = pickData;
                    ownerWrite_d = pickData && d_we;
                    mem_en       = 1'b1;
                    if (pickData) begin
                        d_ready   = 1'b1;
                        mem_we    = d_we;
                        mem_addr  = d_addr;
                        mem_wdata = d_wdata;
                        mem_wstrb = d_wstrb;
                    end else begin
                        i_ready  = 1'b1;
                        mem_addr = i_addr;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ownerData_q  <= 1'b0;
            ownerWrite_q <= 1'b0;
            iRdata_q     <= '0;
            dRdata_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ownerData_q  <= ownerData_d;
            ownerWrite_q <= ownerWrite_d;
            iRdata_q     <= iRdata_d;
            dRdata_q     <= dRdata_d;
        end
    end

endmodule
